blink_meter: RTL
================

BLINK_METER -- requirements
Module: blink_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 26, giving the width of the interval counter and of per_out.
REQ-002 The block SHALL have parameter NOMINAL, default 25000000, giving the expected clocks between input toggles.
REQ-003 The block SHALL have parameter TOL, default 250000, giving the allowed absolute deviation from NOMINAL.
REQ-004 The block SHALL have parameter TIMEOUT, default 50000000, giving the clocks without a toggle before stall is declared.
REQ-005 The block SHALL have parameter LOCK_N, default 2, giving the consecutive in-tolerance measurements needed for lock.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port sig_in, input, 1 bit: the square-wave (blinker) signal to be measured.
REQ-009 The block SHALL have port per_out, output, CNT_W bits: the last measured interval in clocks.
REQ-010 The block SHALL have port per_vld, output, 1 bit: a one-cycle strobe marking per_out as updated.
REQ-011 The block SHALL have port lock, output, 1 bit: the input toggles at NOMINAL±TOL.
REQ-012 The block SHALL have port timeout, output, 1 bit: no input toggle seen for TIMEOUT clocks.
REQ-013 The block SHALL have port meas_cnt, output, 8 bits: a count of completed measurements.

Function
REQ-014 The block SHALL define edge as sig_s differing from its one-cycle-delayed copy sig_d, where sig_s is sig_in after the optional synchronizer (REQ-030/031).
REQ-015 The block SHALL implement states IDLE, MEASURE and STALL, and SHALL enter IDLE on reset.
REQ-016 In IDLE, on edge the block SHALL go to MEASURE with cnt<=1; no per_vld is produced.
REQ-017 In MEASURE, without an edge, cnt SHALL increment by 1 each cycle.
REQ-018 In MEASURE, on edge the block SHALL load per_out<=cnt, pulse per_vld for exactly one cycle, set cnt<=1, and increment meas_cnt (wrapping 255->0).
REQ-019 per_out SHALL therefore equal the clock distance between consecutive detected edges; an input toggling every N clocks yields per_out=N.
REQ-020 A measurement SHALL be in-tolerance iff (NOMINAL-TOL) <= cnt <= (NOMINAL+TOL), using an unsigned compare at CNT_W bits.
REQ-021 Each in-tolerance measurement SHALL increment a good counter that saturates at LOCK_N; lock SHALL assert in the same cycle as the per_vld that makes the count equal LOCK_N.
REQ-022 An out-of-tolerance measurement SHALL clear the good counter and deassert lock in the same cycle as its per_vld.
REQ-023 In MEASURE, when cnt==TIMEOUT and there is no edge, the block SHALL go to STALL: timeout<=1, lock<=0, good counter<=0, cnt held.
REQ-024 When an edge coincides with cnt==TIMEOUT, the edge SHALL win: a normal measurement with per_out=TIMEOUT and no timeout.
REQ-025 In STALL, on edge the block SHALL go to MEASURE with cnt<=1 and timeout<=0; no per_vld is produced, and per_out is unchanged.
REQ-026 per_out SHALL hold its value between strobes.
REQ-027 The outputs per_vld, lock and timeout SHALL be registered (no combinational path from sig_in).

Reset
REQ-028 While rst_n=0 at a rising clk, the block SHALL clear per_out, per_vld, lock, timeout, meas_cnt, cnt, the good counter, sig_d and the synchronizer flops to 0, and set state=IDLE.
REQ-029 A reset asserted mid-measurement SHALL discard the partial interval; the first edge after reset SHALL only start a measurement.

Configuration
REQ-030 With macro BLINK_METER_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer, so per_vld rises 2 clocks after the first rising clk that samples the new sig_in level.
REQ-031 Without BLINK_METER_SYNC_EN, sig_s SHALL be sig_in directly, so per_vld rises on the first rising clk that samples the new sig_in level; measured intervals are identical in both builds.

Verification (NOMINAL=10, TOL=1, TIMEOUT=20, LOCK_N=2)
REQ-032 The bench SHALL cover: rst_n=0 for 3 clocks -> all outputs 0, and no per_vld on the first toggle afterwards.
REQ-033 The bench SHALL cover: sig_in toggled every 10 clocks, 4 toggles -> 3 per_vld strobes with per_out=10, lock=1 from the 2nd strobe, meas_cnt=3.
REQ-034 The bench SHALL cover: while locked, one 12-clock gap -> per_out=12, with lock=0 in the same cycle as per_vld.
REQ-035 The bench SHALL cover: sig_in held for 25 clocks after an edge -> timeout=1 after 20 clocks and lock=0; the next toggle -> timeout=0, no per_vld.
REQ-036 The bench SHALL cover: a toggle exactly 20 clocks after the previous one -> per_vld with per_out=20 and timeout remaining 0.
REQ-037 The bench SHALL cover: rst_n pulsed 5 clocks into an interval -> outputs cleared, the next toggle gives no per_vld, and the toggle after that gives the correct interval; each scenario is run with and without BLINK_METER_SYNC_EN.

Source files
------------

// File: rtl/blink_meter.sv
// Blink-interval meter: measures clocks between sig_in toggles, reports lock/timeout.
// Optional 2-flop input synchronizer enabled by defining BLINK_METER_SYNC_EN.
module blink_meter #(
    parameter int CNT_W   = 26,
    parameter int NOMINAL = 25000000,
    parameter int TOL     = 250000,
    parameter int TIMEOUT = 50000000,
    parameter int LOCK_N  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] per_out,
    output logic             per_vld,
    output logic             lock,
    output logic             timeout,
    output logic [7:0]       meas_cnt
);

    localparam int GW = $clog2(LOCK_N + 2);
    localparam logic [CNT_W-1:0] LO_C   = CNT_W'(NOMINAL - TOL);
    localparam logic [CNT_W-1:0] HI_C   = CNT_W'(NOMINAL + TOL);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, per_nx;
    logic [GW-1:0]    good, good_nx;
    logic [7:0]       mc_nx;
    logic             vld_nx, lock_nx, to_nx;
    logic             sig_s, sig_d, tog, in_tol;

`ifdef BLINK_METER_SYNC_EN
    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    assign sig_s = sync2;
`else
    assign sig_s = sig_in;
`endif

    assign tog    = sig_s ^ sig_d;
    assign in_tol = (cnt >= LO_C) && (cnt <= HI_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            good     <= '0;
            sig_d    <= 1'b0;
            per_out  <= '0;
            per_vld  <= 1'b0;
            lock     <= 1'b0;
            timeout  <= 1'b0;
            meas_cnt <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            good     <= good_nx;
            sig_d    <= sig_s;
            per_out  <= per_nx;
            per_vld  <= vld_nx;
            lock     <= lock_nx;
            timeout  <= to_nx;
            meas_cnt <= mc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        good_nx  = good;
        per_nx   = per_out;
        vld_nx   = 1'b0;
        lock_nx  = lock;
        to_nx    = timeout;
        mc_nx    = meas_cnt;

        case (state)
            IDLE: begin
                if (tog) begin
                    state_nx = MEASURE;
                    cnt_nx   = CNT_W'(1);
                end
            end
            MEASURE: begin
                // An edge landing exactly on the timeout count still counts as a measurement.
                if (tog) begin
                    per_nx = cnt;
                    vld_nx = 1'b1;
                    cnt_nx = CNT_W'(1);
                    mc_nx  = meas_cnt + 8'd1;
                    if (in_tol) begin
                        if (good < LOCK_C) good_nx = good + 1'b1;
                        lock_nx = (good_nx >= LOCK_C);
                    end else begin
                        good_nx = '0;
                        lock_nx = 1'b0;
                    end
                end else if (cnt == TO_C) begin
                    state_nx = STALL;
                    to_nx    = 1'b1;
                    lock_nx  = 1'b0;
                    good_nx  = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STALL: begin
                if (tog) begin
                    state_nx = MEASURE;
                    cnt_nx   = CNT_W'(1);
                    to_nx    = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
